instr_sequencer: RTL
====================

# instr_sequencer

Beat generator and instruction register for the multi-cycle CPU. It drives the 3-bit `timer` phase code and the latched 16-bit `instruction` word that the controller decodes into datapath control. It walks each instruction through fetch, execute and, for memory-class opcodes, two extra memory phases. It also counts retired instructions and latches a halt.

## Interface
Parameters:
- `IW`, default 16: instruction width. Only 16 is supported.
- `CW`, default 16: width of the retired-instruction counter.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `run` in 1: level. Allows a new instruction to begin.
- `mem_data` in IW: memory read data. Sampled at the end of phase 001.
- `step` in 1: single-instruction request. Exists only under `INSTR_SEQ_STEP_EN`.
- `timer` out 3: current phase code, fed to the controller.
- `instruction` out IW: instruction register, fed to the controller.
- `instr_done` out 1: high during the final phase cycle of each instruction.
- `retired_count` out CW: number of instructions completed.
- `halted` out 1: sticky. Set by the HLT instruction.

## Operation
- States and `timer` codes: IDLE=100, FA=000 (address to AR), FD=001 (memory to IR), EX=011, MA=101, MD=111. Every state lasts exactly one cycle.
- IDLE: go to FA when `run`=1 and `halted`=0. Otherwise stay in IDLE.
- FA always goes to FD.
- FD always goes to EX. At the FD clock edge, `instruction` <= `mem_data`.
- EX, memory-class instruction (`instruction[15:12]`=4'b1000): go to MA.
- EX, HLT instruction (`instruction[15:8]`=8'h7F): assert `instr_done`, set `halted`, go to IDLE.
- EX, any other instruction: assert `instr_done`. Go to FA if `run`=1, else IDLE.
- MA always goes to MD.
- MD: assert `instr_done`. Go to FA if `run`=1, else IDLE.
- Opcode values not recognised by the controller are still sequenced as normal 3-phase instructions. The sequencer never stalls on them.
- `retired_count` increments by 1 at the end of every cycle where `instr_done`=1. It wraps from 2^CW−1 to 0.
- `halted` clears only on `reset`. While `halted`=1, the sequencer stays in IDLE and ignores `run` (and `step`, when present).
- Deasserting `run` mid-instruction does not abort the instruction. It completes, then the sequencer enters IDLE.
- `instruction` holds its value from FD until the next FD, so it stays stable through EX/MA/MD and IDLE.

## Timing
- Reset values: `timer`=100, `instruction`=0, `instr_done`=0, `retired_count`=0, `halted`=0.
- Reset asserted in any state, including mid-instruction: all of the above take effect at the next edge. The partial instruction is not counted.
- Latency from `run` rising in IDLE to `timer`=000: 1 cycle.
- Non-memory instruction: 3 cycles (000, 001, 011).
- Memory instruction: 5 cycles (000, 001, 011, 101, 111).
- Back-to-back instructions with `run` held high have no idle gap. FA follows EX or MD directly.
- `instr_done` and `halted` are registered or state-decoded. No combinational path exists from `mem_data` to any output other than through `instruction`.

## Configuration
- `INSTR_SEQ_STEP_EN` defined:
  - The `step` port exists.
  - In IDLE with `run`=0 and `halted`=0, a `step`=1 cycle starts exactly one instruction (IDLE→FA).
  - On completion the sequencer returns to IDLE unless `run`=1.
  - `step` is ignored outside IDLE.
  - If `run` and `step` are both high, `run` wins: continuous execution.
- `INSTR_SEQ_STEP_EN` undefined: no `step` port. IDLE is left only via `run`.

## Test plan
- Basic fetch: reset, then `run`=1 with `mem_data`=16'h0012.
  - `timer` goes 100→000→001→011→000.
  - `instruction`=16'h0012 from the first 011 cycle.
  - `instr_done` pulses once; `retired_count`=1.
- Memory instruction: `mem_data`=16'h8034.
  - `timer` goes 000,001,011,101,111,000.
  - `instr_done` is high only in the 111 cycle.
- Halt: `mem_data`=16'h7F00 with `run`=1.
  - After 011, `timer`=100 and `halted`=1, held for 20 cycles despite `run`=1.
  - `reset` clears `halted`.
- Run drop: deassert `run` during 101.
  - 111 completes, `timer`=100, `retired_count` increments once, no further FA.
- Reset mid-instruction: assert `reset` in 011.
  - Next cycle `timer`=100, `instruction`=0, `retired_count` unchanged from its pre-instruction value (0 after a first instruction).
- With `CW`=4, run 17 non-memory instructions: `retired_count` reaches 15, wraps to 0, then reads 1.
- Under `INSTR_SEQ_STEP_EN`: `run`=0 with one `step` pulse gives exactly one instruction, then 100 again.

Source files
------------

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//
// Beat generator and instruction register for the multi-cycle CPU. Each
// instruction walks through fetch-address (FA), fetch-data (FD) and execute
// (EX). Memory-class opcodes (top nibble 4'b1000) add the MA and MD phases.
// Opcode HLT (top byte 8'h7F) retires and sets a sticky halt. The module also
// counts retired instructions.
//
// The FSM state encoding is the timer phase code itself, so `timer` is also
// the observable FSM state:
//   IDLE=100  FA=000  FD=001  EX=011  MA=101  MD=111
//
// Optional feature macro: INSTR_SEQ_STEP_EN
//   When it is defined, the `step` input exists. A single-cycle `step` pulse
//   in IDLE with run=0 and halted=0 launches exactly one instruction. `run`
//   takes priority over `step`.
//
// Parameters:
//   IW  instruction width (only 16 is supported)
//   CW  retired-instruction counter width
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high reset
//   run            in   level; allows a new instruction to begin
//   mem_data       in   memory read data, latched into `instruction` at FD
//   step           in   single-instruction request (INSTR_SEQ_STEP_EN only)
//   timer          out  current phase code / FSM state
//   instruction    out  instruction register
//   instr_done     out  high in the final phase cycle of each instruction
//   retired_count  out  completed-instruction count, wraps at 2^CW
//   halted         out  sticky halt flag, cleared only by reset
//
// Start handshake: `run` (or `step`) is sampled only while in IDLE, and at
// EX/MD when deciding whether to chain straight into the next FA. Dropping
// `run` never aborts an instruction that is already in progress.
// ---------------------------------------------------------------------------
module instr_sequencer #(
    parameter int IW = 16,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic [IW-1:0] mem_data,
`ifdef INSTR_SEQ_STEP_EN
    input  logic          step,
`endif
    output logic [2:0]    timer,
    output logic [IW-1:0] instruction,
    output logic          instr_done,
    output logic [CW-1:0] retired_count,
    output logic          halted
);

    typedef enum logic [2:0] {
        IDLE = 3'b100,
        FA   = 3'b000,
        FD   = 3'b001,
        EX   = 3'b011,
        MA   = 3'b101,
        MD   = 3'b111
    } state_t;

    state_t state;
    state_t next_state;
    logic   start;
    logic   is_mem;
    logic   is_hlt;
    logic   set_halt;

    // Decode from the registered instruction only. This keeps mem_data off
    // every combinational output path.
    assign is_mem = (instruction[IW-1 -: 4] == 4'b1000);
    assign is_hlt = (instruction[IW-1 -: 8] == 8'h7F);

`ifdef INSTR_SEQ_STEP_EN
    assign start = !halted && (run || step);
`else
    assign start = !halted && run;
`endif

    always_comb begin
        next_state = state;
        instr_done = 1'b0;
        set_halt   = 1'b0;
        case (state)
            IDLE: if (start) next_state = FA;
            FA:   next_state = FD;
            FD:   next_state = EX;
            EX: begin
                if (is_mem) begin
                    next_state = MA;
                end else if (is_hlt) begin
                    instr_done = 1'b1;
                    set_halt   = 1'b1;
                    next_state = IDLE;
                end else begin
                    // Unrecognised opcodes also retire here as plain
                    // three-phase instructions.
                    instr_done = 1'b1;
                    next_state = run ? FA : IDLE;
                end
            end
            MA:   next_state = MD;
            MD: begin
                instr_done = 1'b1;
                next_state = run ? FA : IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            instruction   <= '0;
            retired_count <= '0;
            halted        <= 1'b0;
        end else begin
            state <= next_state;
            if (state == FD) instruction <= mem_data;
            if (instr_done) retired_count <= retired_count + CW'(1);
            if (set_halt) halted <= 1'b1;
        end
    end

    assign timer = state;

endmodule
